// File: rtl/cargador_programa.sv
// Boot loader for the single-cycle core's instruction memory.
// Accepts a framed program (16-bit big-endian word count, payload bytes,
// XOR checksum) over a byte valid/ready handshake. It packs the payload into
// 32-bit big-endian words and writes each one with a one-cycle strobe. It
// releases the core via cpu_run only once the checksum matches.
// Optional build macro: CARGADOR_TIMEOUT_EN adds an idle-byte watchdog
// (TIMEOUT_CYC cycles) in HDR_LO, DATA and CHK that ends in err_code 11.
module cargador_programa #(
  parameter int ADDR_W      = 6,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              EscrInstru,
  output logic [ADDR_W-1:0] DirInstru,
  output logic [31:0]       DatoInstru,
  output logic              cpu_run,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words_loaded
);

  // Elaboration-time sanity checks on the configuration.
  if (ADDR_W < 1 || ADDR_W > 15) begin : g_bad_addr_w
    $error("cargador_programa: ADDR_W must be in 1..15");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("cargador_programa: TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DATA,
    CHK,
    DONE,
    ERROR
  } state_t;

  localparam logic [16:0]     MAX_WORDS = 17'd1 << ADDR_W;
  localparam logic [ADDR_W:0] ONE_WORD  = {{ADDR_W{1'b0}}, 1'b1};

  state_t      state;
  state_t      state_nxt;

  logic        accept;
  logic        restart;
  logic        word_done;
  logic        set_err;
  logic [1:0]  err_nxt;
  logic        tmo_hit;

  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [23:0] shift;
  logic [1:0]  byte_idx;
  logic [7:0]  chk;
  logic [16:0] header_len;
  logic [16:0] next_count;

  // The handshake is a pure state decode, so ready never depends on valid.
  assign byte_ready = (state == HDR_HI) || (state == HDR_LO) ||
                      (state == DATA)   || (state == CHK);
  assign accept     = byte_valid && byte_ready;
  assign cpu_run    = (state == DONE);
  assign header_len = {1'b0, len_hi, byte_data};
  assign next_count = 17'(words_loaded) + 17'd1;

`ifdef CARGADOR_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_hit = ((state == HDR_LO) || (state == DATA) || (state == CHK)) &&
                   !accept && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  // The idle counter restarts on every accepted byte and on entering the header.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (restart || accept) begin
      tmo_cnt <= '0;
    end else if ((state == HDR_LO) || (state == DATA) || (state == CHK)) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus the control pulses used by the datapath.
  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    word_done = 1'b0;
    set_err   = 1'b0;
    err_nxt   = 2'b00;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = HDR_HI;
          restart   = 1'b1;
        end
      end
      HDR_HI: begin
        if (accept) begin
          state_nxt = HDR_LO;
        end
      end
      HDR_LO: begin
        if (accept) begin
          if (header_len > MAX_WORDS) begin
            state_nxt = ERROR;
            set_err   = 1'b1;
            err_nxt   = 2'b01;
          end else if (header_len == 17'd0) begin
            state_nxt = CHK;
          end else begin
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (accept && (byte_idx == 2'd3)) begin
          word_done = 1'b1;
          if (next_count == {1'b0, len}) begin
            state_nxt = CHK;
          end
        end
      end
      CHK: begin
        if (accept) begin
          if (byte_data == chk) begin
            state_nxt = DONE;
          end else begin
            state_nxt = ERROR;
            set_err   = 1'b1;
            err_nxt   = 2'b10;
          end
        end
      end
      DONE, ERROR: begin
        if (start) begin
          state_nxt = HDR_HI;
          restart   = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (tmo_hit) begin
      state_nxt = ERROR;
      set_err   = 1'b1;
      err_nxt   = 2'b11;
    end
  end

  // Header latch, word assembly, checksum and the memory write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_hi       <= '0;
      len          <= '0;
      shift        <= '0;
      byte_idx     <= '0;
      chk          <= '0;
      err_code     <= '0;
      words_loaded <= '0;
      EscrInstru   <= 1'b0;
      DirInstru    <= '0;
      DatoInstru   <= '0;
    end else begin
      EscrInstru <= word_done;
      if (restart) begin
        err_code     <= '0;
        words_loaded <= '0;
        chk          <= '0;
        byte_idx     <= '0;
      end
      if (set_err) begin
        err_code <= err_nxt;
      end
      if ((state == HDR_HI) && accept) begin
        len_hi <= byte_data;
      end
      if ((state == HDR_LO) && accept) begin
        len <= {len_hi, byte_data};
      end
      if ((state == DATA) && accept) begin
        chk      <= chk ^ byte_data;
        byte_idx <= byte_idx + 2'd1;
        shift    <= {shift[15:0], byte_data};
      end
      if (word_done) begin
        DirInstru    <= words_loaded[ADDR_W-1:0];
        DatoInstru   <= {shift, byte_data};
        words_loaded <= words_loaded + ONE_WORD;
      end
    end
  end

endmodule

// File: tb/tb_cargador_programa.sv
// Self-checking bench for cargador_programa: frames are fed through the byte
// handshake, expected memory writes are queued as each frame is built, and a
// strobe monitor pops and compares them as the loader writes.
module tb_cargador_programa;

  localparam int ADDR_W = 6;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [ADDR_W:0]   wl;
  } wr_t;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              EscrInstru;
  logic [ADDR_W-1:0] DirInstru;
  logic [31:0]       DatoInstru;
  logic              cpu_run;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   words_loaded;

  int   tests_run;
  int   tests_failed;
  wr_t  exp_q[$];
  logic [7:0] frame_q[$];

  cargador_programa #(
    .ADDR_W     (ADDR_W),
    .TIMEOUT_CYC(10)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_ready  (byte_ready),
    .EscrInstru  (EscrInstru),
    .DirInstru   (DirInstru),
    .DatoInstru  (DatoInstru),
    .cpu_run     (cpu_run),
    .err_code    (err_code),
    .words_loaded(words_loaded)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the bench itself wedges.
  initial begin
    #3000000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  // Strobe monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && EscrInstru) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL unexpected_write: addr=%0d data=%h, no write expected",
                 DirInstru, DatoInstru);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if ({DirInstru, DatoInstru, words_loaded} !== {e.addr, e.data, e.wl}) begin
          tests_failed++;
          $display("[TB] FAIL write: got addr=%0d data=%h wl=%0d, required addr=%0d data=%h wl=%0d",
                   DirInstru, DatoInstru, words_loaded, e.addr, e.data, e.wl);
        end
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL ready_wait: byte_ready=%0b required=1", byte_ready);
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_frame(input int max_gap);
    foreach (frame_q[i]) begin
      send_byte(frame_q[i], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
    end
  endtask

  task automatic build_nominal(input logic [7:0] chk_byte);
    frame_q = '{8'h00, 8'h02, 8'h8C, 8'h01, 8'h00, 8'h04,
                8'hAC, 8'h02, 8'h00, 8'h08, chk_byte};
  endtask

  task automatic expect_nominal();
    exp_q.push_back('{addr: 6'd0, data: 32'h8C010004, wl: 7'd1});
    exp_q.push_back('{addr: 6'd1, data: 32'hAC020008, wl: 7'd2});
  endtask

  task automatic check_end(input string name, input logic run_exp,
                           input logic [1:0] err_exp, input logic [ADDR_W:0] wl_exp);
    tests_run++;
    if ({cpu_run, err_code, words_loaded} !== {run_exp, err_exp, wl_exp}) begin
      tests_failed++;
      $display("[TB] FAIL %s: got run=%0b err=%b wl=%0d, required run=%0b err=%b wl=%0d",
               name, cpu_run, err_code, words_loaded, run_exp, err_exp, wl_exp);
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL %s_writes: %0d writes missing, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({byte_ready, EscrInstru, DirInstru, DatoInstru, cpu_run, err_code, words_loaded} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: ready=%0b wr=%0b addr=%0d data=%h run=%0b err=%b wl=%0d, required all 0",
               byte_ready, EscrInstru, DirInstru, DatoInstru, cpu_run, err_code, words_loaded);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (byte_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL idle_ready: got %0b required 0", byte_ready);
    end
  endtask

  task automatic test_nominal();
    pulse_start();
    build_nominal(8'h2F);
    expect_nominal();
    send_frame(0);
    check_end("nominal", 1'b1, 2'b00, 7'd2);
  endtask

  task automatic test_bad_checksum();
    pulse_start();
    build_nominal(8'h2E);
    expect_nominal();
    send_frame(0);
    check_end("bad_checksum", 1'b0, 2'b10, 7'd2);
  endtask

  task automatic test_length_overflow();
    pulse_start();
    frame_q = '{8'h00, 8'h41};
    send_frame(0);
    check_end("length_overflow", 1'b0, 2'b01, 7'd0);
    tests_run++;
    if (byte_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL overflow_ready: got %0b required 0", byte_ready);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_empty();
    pulse_start();
    frame_q = '{8'h00, 8'h00, 8'h00};
    send_frame(0);
    check_end("empty_ok", 1'b1, 2'b00, 7'd0);
    pulse_start();
    frame_q = '{8'h00, 8'h00, 8'h01};
    send_frame(0);
    check_end("empty_badchk", 1'b0, 2'b10, 7'd0);
  endtask

  task automatic test_start_ignored();
    pulse_start();
    expect_nominal();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h8C, 0);
    pulse_start();
    frame_q = '{8'h01, 8'h00, 8'h04, 8'hAC, 8'h02, 8'h00, 8'h08, 8'h2F};
    send_frame(0);
    check_end("start_ignored", 1'b1, 2'b00, 7'd2);
  endtask

  task automatic test_throttled();
    pulse_start();
    build_nominal(8'h2F);
    expect_nominal();
    send_frame(3);
    check_end("throttled", 1'b1, 2'b00, 7'd2);
  endtask

  task automatic test_reset_midload();
    pulse_start();
    exp_q.push_back('{addr: 6'd0, data: 32'h8C010004, wl: 7'd1});
    frame_q = '{8'h00, 8'h02, 8'h8C, 8'h01, 8'h00, 8'h04, 8'hAC};
    send_frame(0);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({byte_ready, EscrInstru, DirInstru, DatoInstru, cpu_run, err_code, words_loaded} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL midload_reset: ready=%0b wr=%0b addr=%0d data=%h run=%0b err=%b wl=%0d, required all 0",
               byte_ready, EscrInstru, DirInstru, DatoInstru, cpu_run, err_code, words_loaded);
    end
    check_end("midload_partial", 1'b0, 2'b00, 7'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    build_nominal(8'h2F);
    expect_nominal();
    send_frame(0);
    check_end("reload", 1'b1, 2'b00, 7'd2);
  endtask

  task automatic test_full_capacity();
    logic [7:0]  c;
    logic [31:0] w;
    c = 8'h00;
    frame_q = '{8'h00, 8'h40};
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      exp_q.push_back('{addr: 6'(i), data: w, wl: 7'(i + 1)});
      for (int k = 3; k >= 0; k--) begin
        frame_q.push_back(w[k*8 +: 8]);
        c = c ^ w[k*8 +: 8];
      end
    end
    frame_q.push_back(c);
    pulse_start();
    send_frame(0);
    check_end("full_capacity", 1'b1, 2'b00, 7'd64);
  endtask

  task automatic test_stall();
    int n;
    pulse_start();
    frame_q = '{8'h00, 8'h02, 8'h8C, 8'h01, 8'h00};
    send_frame(0);
`ifdef CARGADOR_TIMEOUT_EN
    n = 0;
    while (err_code !== 2'b11 && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (n != 10) begin
      tests_failed++;
      $display("[TB] FAIL timeout_cycles: got %0d idle cycles (err=%b), required 10", n, err_code);
    end
    check_end("timeout_state", 1'b0, 2'b11, 7'd0);
    pulse_start();
    build_nominal(8'h2F);
    expect_nominal();
    send_frame(0);
    check_end("timeout_restart", 1'b1, 2'b00, 7'd2);
`else
    n = 0;
    repeat (20) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if ({err_code, byte_ready} !== {2'b00, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL stall_wait: got err=%b ready=%0b after %0d cycles, required err=00 ready=1",
               err_code, byte_ready, n);
    end
    expect_nominal();
    frame_q = '{8'h04, 8'hAC, 8'h02, 8'h00, 8'h08, 8'h2F};
    send_frame(0);
    check_end("stall_resume", 1'b1, 2'b00, 7'd2);
`endif
  endtask

  // Test sequence.
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    start        = 1'b0;
    byte_valid   = 1'b0;
    byte_data    = 8'h00;
    rst_n        = 1'b0;
    @(negedge clk);
    test_reset();
    test_nominal();
    test_bad_checksum();
    test_length_overflow();
    test_empty();
    test_start_ignored();
    test_throttled();
    test_reset_midload();
    test_full_capacity();
    test_stall();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
